draw_arbiter: RTL and testbench
===============================

# draw_arbiter

Shares the single VGA adapter pixel port between three sprite engines: rocket (0), shot (1) and alien grid (2). Each engine requests a solid rectangle fill (draw or erase colour) at a screen position. The arbiter grants one requester at a time in round-robin order, scans the rectangle one pixel per clock onto the adapter's plot interface, and pulses a per-requester done. It sits between the game datapaths and the 160x120, 3-bit-colour VGA adapter.

## Interface
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are suppressed
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are suppressed
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  3  request per requester; held high until that requester's done
- reqX  in  24  top-left x, 8 bits per requester, requester i at [8i+7:8i]
- reqY  in  21  top-left y, 7 bits per requester, [7i+6:7i]
- reqW  in  12  width minus 1, 4 bits per requester (1..16 px), [4i+3:4i]
- reqH  in  12  height minus 1, 4 bits per requester, [4i+3:4i]
- reqColour  in  9  fill colour, 3 bits per requester, [3i+2:3i]
- grant  out  3  one-hot, high from LOAD through the last SCAN cycle
- done  out  3  one-cycle pulse on the granted bit in DONE state
- plotX  out  8  pixel x to adapter
- plotY  out  7  pixel y to adapter
- plotColour  out  3  pixel colour to adapter
- plot  out  1  adapter write enable
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, SCAN, DONE.
- IDLE: if req != 0, select the winner by round robin, searching from (last+1) mod 3 upward; go to LOAD. Otherwise stay in IDLE.
- LOAD: latch the winner's x0, y0, W, H and colour into internal registers. Clear counters cx = cy = 0. Set grant[winner]. Update last = winner. Go to SCAN.
- SCAN, one pixel per cycle:
  - plotX = x0+cx, plotY = y0+cy, plotColour = latched colour.
  - cx counts 0..W. On wrap, cx returns to 0 and cy increments.
  - When cx == W and cy == H, go to DONE.
  - Total SCAN cycles = (W+1)*(H+1), range 1..256.
- Clipping: sums are computed at 9/8 bits. plot = 1 only when x0+cx < SCREEN_W and y0+cy < SCREEN_H. A suppressed pixel still consumes its cycle. Coordinates never wrap onto the screen.
- DONE: done[winner] = 1 for exactly one cycle, grant = 0; go to IDLE.
- Requests sampled only in IDLE:
  - Deassertion of req mid-transfer is ignored; the rectangle completes.
  - Input field changes after LOAD have no effect.
- A requester that still holds req in the IDLE cycle after its DONE is eligible again, but the round robin favours the others.
- Reset values:
  - state IDLE, last = 2 (requester 0 has top priority after reset)
  - grant = 0, done = 0, plot = 0, busy = 0
  - plotX = 0, plotY = 0, plotColour = 0, counters 0
- Reset mid-SCAN aborts immediately: no done pulse, and plot is 0 from the next cycle.

## Timing
- Req seen high in IDLE at cycle t:
  - LOAD at t+1 (grant visible)
  - first plot at t+2
  - last plot at t+1+(W+1)(H+1)
  - done the following cycle
  - IDLE one cycle after that
- Minimum spacing between back-to-back transfers: 3 overhead cycles (IDLE, LOAD, DONE) plus the pixel count.
- plot, plotX, plotY and plotColour are registered. The adapter sees each pixel on the cycle it is asserted; there is no stall input.
- req, grant and done form a 4-phase handshake. The requester must hold its fields stable from raising req until LOAD, and may drop req on the cycle done is seen.

## Test plan
- Single 1x1: reset, then req=001, x=10, y=20, W=H=0, colour=111. Required: grant=001 at t+1; one plot at (10,20,111) at t+2; done=001 at t+3; busy low at t+4.
- 4x2 scan order: requester 1 at x=50, y=100, W=3, H=1, colour=111. Required: 8 plots in order (50..53,100) then (50..53,101); done[1] on the 9th cycle after grant.
- Clipping: requester 2 at x=158, y=118, W=3, H=3. Required: 16 SCAN cycles; plot high only at (158,118), (159,118), (158,119), (159,119).
- Round robin: all three requesters hold req continuously with 1x1 rectangles. Required: grant sequence 0,1,2,0,1,2, no requester starved; each transfer is 4 cycles.
- Mid-transfer drop: requester 0 drops req during SCAN of a 16x16 rectangle. Required: all 256 pixels still plotted and done[0] pulses.
- Reset mid-SCAN: assert reset 5 cycles into a 16x16 scan. Required: plot=0 and grant=0 from the next cycle, no done pulse; a subsequent req=111 grants requester 0 first.

Source files
------------

// File: rtl/draw_arbiter.sv
// Round-robin arbiter that gives three sprite engines turns on the VGA adapter pixel port.
// The granted requester's rectangle is scanned one pixel per clock, clipped to the visible screen.
module draw_arbiter #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] reqX,
  input  logic [20:0] reqY,
  input  logic [11:0] reqW,
  input  logic [11:0] reqH,
  input  logic [8:0]  reqColour,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [7:0]  plotX,
  output logic [6:0]  plotY,
  output logic [2:0]  plotColour,
  output logic        plot,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

  state_t      state, state_nxt;
  logic [1:0]  last;
  logic [1:0]  winner;
  logic        win_valid;

  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [3:0]  sel_w, sel_h;
  logic [2:0]  sel_c;

  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [3:0]  wm, hm;
  logic [2:0]  col;
  logic [3:0]  cx, cy;
  logic [3:0]  cx_n, cy_n;
  logic        last_pixel;
  logic        pix_on;
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  logic        in_view;

  // Priority rotates so the search starts just after the previous winner.
  always_comb begin
    winner    = 2'd0;
    win_valid = |req;
    case (last)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_w = '0;
    sel_h = '0;
    sel_c = '0;
    case (winner)
      2'd0: begin
        sel_x = reqX[7:0];
        sel_y = reqY[6:0];
        sel_w = reqW[3:0];
        sel_h = reqH[3:0];
        sel_c = reqColour[2:0];
      end
      2'd1: begin
        sel_x = reqX[15:8];
        sel_y = reqY[13:7];
        sel_w = reqW[7:4];
        sel_h = reqH[7:4];
        sel_c = reqColour[5:3];
      end
      2'd2: begin
        sel_x = reqX[23:16];
        sel_y = reqY[20:14];
        sel_w = reqW[11:8];
        sel_h = reqH[11:8];
        sel_c = reqColour[8:6];
      end
      default: ;
    endcase
  end

  assign last_pixel = (cx == wm) && (cy == hm);

  // Counters are computed one cycle ahead so the pixel outputs can be registered.
  always_comb begin
    state_nxt = state;
    cx_n      = cx;
    cy_n      = cy;
    case (state)
      IDLE: begin
        cx_n = '0;
        cy_n = '0;
        if (win_valid) state_nxt = LOAD;
      end
      LOAD: begin
        cx_n      = '0;
        cy_n      = '0;
        state_nxt = SCAN;
      end
      SCAN: begin
        if (last_pixel) begin
          state_nxt = DONE;
        end else if (cx == wm) begin
          cx_n = '0;
          cy_n = cy + 4'd1;
        end else begin
          cx_n = cx + 4'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_on  = (state_nxt == SCAN);
    sum_x   = {1'b0, x0} + {5'b0, cx_n};
    sum_y   = {1'b0, y0} + {4'b0, cy_n};
    in_view = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 2'd2;
      grant      <= '0;
      done       <= '0;
      plot       <= 1'b0;
      plotX      <= '0;
      plotY      <= '0;
      plotColour <= '0;
      cx         <= '0;
      cy         <= '0;
      x0         <= '0;
      y0         <= '0;
      wm         <= '0;
      hm         <= '0;
      col        <= '0;
    end else begin
      state <= state_nxt;
      cx    <= cx_n;
      cy    <= cy_n;
      done  <= '0;
      if (state == IDLE && win_valid) begin
        x0    <= sel_x;
        y0    <= sel_y;
        wm    <= sel_w;
        hm    <= sel_h;
        col   <= sel_c;
        grant <= 3'b001 << winner;
        last  <= winner;
      end
      if (state == SCAN && last_pixel) begin
        grant <= '0;
        done  <= grant;
      end
      plot <= pix_on && in_view;
      if (pix_on) begin
        plotX      <= sum_x[7:0];
        plotY      <= sum_y[6:0];
        plotColour <= col;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed and randomized checks of draw_arbiter against a rectangle/round-robin reference model.
module tb_draw_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] reqX;
  logic [20:0] reqY;
  logic [11:0] reqW;
  logic [11:0] reqH;
  logic [8:0]  reqColour;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [7:0]  plotX;
  logic [6:0]  plotY;
  logic [2:0]  plotColour;
  logic        plot;
  logic        busy;

  logic [7:0] tx [3];
  logic [6:0] ty [3];
  logic [3:0] tw [3];
  logic [3:0] th [3];
  logic [2:0] tc [3];

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned fail_cnt  = 0;
  int unsigned last_m    = 2;

  draw_arbiter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .reqX       (reqX),
    .reqY       (reqY),
    .reqW       (reqW),
    .reqH       (reqH),
    .reqColour  (reqColour),
    .grant      (grant),
    .done       (done),
    .plotX      (plotX),
    .plotY      (plotY),
    .plotColour (plotColour),
    .plot       (plot),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pack();
    reqX      = {tx[2], tx[1], tx[0]};
    reqY      = {ty[2], ty[1], ty[0]};
    reqW      = {tw[2], tw[1], tw[0]};
    reqH      = {th[2], th[1], th[0]};
    reqColour = {tc[2], tc[1], tc[0]};
  endtask

  task automatic set_req(input int unsigned i, input int unsigned x, input int unsigned y,
                         input int unsigned w, input int unsigned h, input int unsigned c);
    tx[i] = 8'(x);
    ty[i] = 7'(y);
    tw[i] = 4'(w);
    th[i] = 4'(h);
    tc[i] = 3'(c);
    pack();
  endtask

  task automatic rand_req(input int unsigned i);
    set_req(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  // Next owner: first requester found scanning upward from the one after the last owner.
  function automatic int unsigned rr(input logic [2:0] r, input int unsigned l);
    for (int unsigned k = 1; k <= 3; k++)
      if (r[(l + k) % 3]) return (l + k) % 3;
    return 99;
  endfunction

  // Starts from an IDLE cycle with req already driven; ends on the following IDLE cycle.
  task automatic xfer(input bit keep, input bit drop);
    int unsigned ew, n, ex, ey;
    logic [7:0]  sx;
    logic [6:0]  sy;
    logic [3:0]  sw, sh;
    logic [2:0]  sc;
    bit          eplot;
    ew = rr(req, last_m);
    if (ew > 2) return;
    sx = tx[ew]; sy = ty[ew]; sw = tw[ew]; sh = th[ew]; sc = tc[ew];
    chk("busy_idle", busy, 0);
    step();
    chk("grant_load", grant, 32'(1) << ew);
    chk("busy_load", busy, 1);
    chk("plot_load", plot, 0);
    last_m = ew;
    n = 0;
    for (int unsigned yy = 0; yy <= sh; yy++) begin
      for (int unsigned xx = 0; xx <= sw; xx++) begin
        if (drop && n == 3) begin
          req[ew] = 1'b0;
          rand_req(ew);
        end
        step();
        n++;
        ex    = sx + xx;
        ey    = sy + yy;
        eplot = (ex < 160) && (ey < 120);
        chk("plot", plot, eplot);
        chk("grant_scan", grant, 32'(1) << ew);
        if (eplot) begin
          chk("plotX", plotX, ex);
          chk("plotY", plotY, ey);
          chk("plotColour", plotColour, sc);
        end
      end
    end
    step();
    chk("done_pulse", done, 32'(1) << ew);
    chk("grant_done", grant, 0);
    chk("plot_done", plot, 0);
    chk("busy_done", busy, 1);
    if (!keep) req[ew] = 1'b0;
    step();
    chk("done_clear", done, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    for (int unsigned i = 0; i < 3; i++) set_req(i, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plotX", plotX, 0);
    chk("rst_plotY", plotY, 0);
    chk("rst_colour", plotColour, 0);
    reset = 1'b0;

    // Single 1x1 pixel
    set_req(0, 10, 20, 0, 0, 7);
    req = 3'b001;
    xfer(1'b0, 1'b0);

    // 4x2 scan order
    set_req(1, 50, 100, 3, 1, 7);
    req = 3'b010;
    xfer(1'b0, 1'b0);

    // Clipping at the bottom-right corner
    set_req(2, 158, 118, 3, 3, 5);
    req = 3'b100;
    xfer(1'b0, 1'b0);

    // Round robin with everyone holding requests
    set_req(0, 1, 2, 0, 0, 1);
    set_req(1, 3, 4, 0, 0, 2);
    set_req(2, 5, 6, 0, 0, 3);
    req = 3'b111;
    for (int unsigned k = 0; k < 6; k++) xfer(1'b1, 1'b0);
    req = '0;
    step();

    // Requester 0 drops req mid-scan of a 16x16 rectangle
    set_req(0, 20, 30, 15, 15, 6);
    req = 3'b001;
    xfer(1'b0, 1'b1);

    // Randomized groups
    for (int unsigned g = 0; g < 12; g++) begin
      for (int unsigned i = 0; i < 3; i++) rand_req(i);
      req = 3'($urandom_range(1, 7));
      for (int unsigned k = 0; k < 4 && req != 0; k++)
        xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      req = '0;
      step();
    end

    // Reset five cycles into a 16x16 scan
    set_req(1, 40, 40, 15, 15, 4);
    req = 3'b010;
    step();
    chk("abort_grant_load", grant, 3'b010);
    for (int unsigned k = 0; k < 5; k++) step();
    chk("abort_plot_before", plot, 1);
    reset = 1'b1;
    req   = '0;
    step();
    chk("abort_plot", plot, 0);
    chk("abort_grant", grant, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    reset  = 1'b0;
    last_m = 2;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_no_plot", plot, 0);
    end
    set_req(0, 7, 8, 0, 0, 1);
    set_req(1, 9, 10, 1, 0, 2);
    set_req(2, 11, 12, 0, 1, 3);
    req = 3'b111;
    for (int unsigned k = 0; k < 3; k++) xfer(1'b0, 1'b0);
    chk("drained_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
